// File: rtl/ps2_scan_rx_pkg.sv
// Shared definitions for the PS/2 scan-code receiver.
// Holds the frame FSM encoding, the prefix bytes that steer decode,
// and the odd-parity check used when a frame completes.
package ps2_scan_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } frame_state_t;

  localparam logic [7:0] BREAK    = 8'hF0;
  localparam logic [7:0] EXTENDED = 8'hE0;

  // PS/2 uses odd parity: data bits plus the parity bit hold an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] dat, input logic par);
    return (^dat) ^ par;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the PS/2 clock and data lines and de-glitches the clock.
// Ports: clk/reset; ps2c_i/ps2d_i raw lines; filt_o filtered clock level,
//        fall_o one-cycle strobe on filtered 1->0, data_o synced data line.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_i,
  input  logic ps2d_i,
  output logic filt_o,
  output logic fall_o,
  output logic data_o
);

  logic [1:0]            c_sync_q;
  logic [1:0]            d_sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic [FILTER_LEN-1:0] hist_d;
  logic                  filt_q;
  logic                  filt_d;

  // History includes the sample being shifted in this cycle, so the filtered
  // level changes on the same edge the FILTER_LEN-th agreeing sample arrives.
  always_comb begin
    hist_d = {hist_q[FILTER_LEN-2:0], c_sync_q[1]};
    filt_d = filt_q;
    if (&hist_d)       filt_d = 1'b1;
    else if (~|hist_d) filt_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      hist_q   <= '1;
      filt_q   <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c_i};
      d_sync_q <= {d_sync_q[0], ps2d_i};
      hist_q   <= hist_d;
      filt_q   <= filt_d;
    end
  end

  assign filt_o = filt_q;
  // Asserted in the cycle before filt_q drops, so the consumer samples on that edge.
  assign fall_o = filt_q & ~filt_d;
  assign data_o = d_sync_q[1];

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frames 11-bit serial words and emits make codes.
// Ports: clk/reset; ps2c/ps2d keyboard lines (input only); ps2_data last make
//        code, ps2_new_data one-cycle strobe, frame_err one-cycle error pulse.
module ps2_scan_rx
  import ps2_scan_rx_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] ps2_data,
  output logic       ps2_new_data,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic filt_clk_unused;
  logic fall;
  logic data_s;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk    (clk),
    .reset  (reset),
    .ps2c_i (ps2c),
    .ps2d_i (ps2d),
    .filt_o (filt_clk_unused),
    .fall_o (fall),
    .data_o (data_s)
  );

  frame_state_t state_q;
  logic [3:0]   bit_cnt_q;
  logic [7:0]   shift_q;
  logic         parity_q;
  logic         frame_ok_q;
  logic [TW-1:0] tmo_q;
  logic         frame_err_q;

  // Frame FSM. The validity verdict is taken on the stop-bit sample so that
  // frame_err is already high during the DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      frame_ok_q  <= 1'b0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tmo_q <= '0;
          if (fall && !data_s) begin
            state_q   <= ST_RECV;
            bit_cnt_q <= 4'd0;
          end
        end
        ST_RECV: begin
          if (fall) begin
            tmo_q     <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q < 4'd8) begin
              shift_q <= {data_s, shift_q[7:1]};
            end else if (bit_cnt_q == 4'd8) begin
              parity_q <= data_s;
            end else begin
              frame_ok_q  <= parity_ok(shift_q, parity_q) & data_s;
              frame_err_q <= ~(parity_ok(shift_q, parity_q) & data_s);
              state_q     <= ST_DONE;
            end
          end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            tmo_q       <= '0;
            state_q     <= ST_IDLE;
            frame_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= 4'd0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic       skip_q;
  logic [7:0] data_q;
  logic       new_q;

  // Decode runs in the DONE cycle; its registered result shows up one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip_q <= 1'b0;
      data_q <= 8'h00;
      new_q  <= 1'b0;
    end else begin
      new_q <= 1'b0;
      if (state_q == ST_DONE && frame_ok_q) begin
        if (shift_q == BREAK) begin
          skip_q <= 1'b1;
        end else if (shift_q == EXTENDED) begin
          skip_q <= skip_q;
        end else if (skip_q) begin
          skip_q <= 1'b0;
        end else begin
          data_q <= shift_q;
          new_q  <= 1'b1;
        end
      end
    end
  end

  assign ps2_data     = data_q;
  assign ps2_new_data = new_q;
  assign frame_err    = frame_err_q;

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: clk cycles a PS/2 clock level must be stable to be accepted.
REQ-002 Parameter TIMEOUT_CYC, default 200000: idle clk cycles tolerated mid-frame before abort (2 ms at 100 MHz).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ps2c  input  1  PS/2 clock line from keyboard, asynchronous.
REQ-006 ps2d  input  1  PS/2 data line from keyboard, asynchronous.
REQ-007 ps2_data  output  8  last accepted make scan code, held until next accepted code.
REQ-008 ps2_new_data  output  1  one-cycle pulse marking a new value on ps2_data.
REQ-009 frame_err  output  1  one-cycle pulse on start, parity or stop error, or timeout.

Function
REQ-010 ps2c and ps2d SHALL each pass through a 2-flop synchronizer before use.
REQ-011 Filtered clock SHALL go 1 after FILTER_LEN consecutive synced-high samples, go 0 after FILTER_LEN consecutive synced-low samples, and otherwise hold.
REQ-012 A bit SHALL be sampled from synced ps2d on each 1-to-0 transition of the filtered clock only.
REQ-013 Frame FSM states SHALL be IDLE, RECV, DONE.
REQ-014 IDLE: on a sampled 0 (start bit), go to RECV with bit count 0; on a sampled 1, stay in IDLE and leave frame_err low.
REQ-015 RECV: shift 8 data bits LSB first, then the parity bit, then the stop bit; on the stop-bit sample, go to DONE.
REQ-016 DONE (one cycle): the frame is valid iff XOR(data, parity) = 1 (odd parity) and stop = 1; the FSM then returns to IDLE.
REQ-017 Invalid frame: pulse frame_err in the DONE cycle, discard the byte, and leave the decode state unchanged.
REQ-018 Timeout: in RECV, a counter SHALL reset on every sampled bit; reaching TIMEOUT_CYC without a sample SHALL abort to IDLE and pulse frame_err for one cycle.
REQ-019 The decode layer SHALL keep a skip flag, cleared at reset, and process each valid byte as follows.
REQ-020 Byte 0xF0: set skip; no output.
REQ-021 Byte 0xE0: no output; skip unchanged.
REQ-022 Any other byte with skip set: clear skip; no output (break code swallowed).
REQ-023 Any other byte with skip clear: load ps2_data and pulse ps2_new_data.
REQ-024 Latency: ps2_new_data SHALL be high exactly in the clk cycle after the DONE cycle, with ps2_data already updated in that same cycle.
REQ-025 ps2_new_data and frame_err SHALL never be high in the same cycle, and neither SHALL be high for 2 consecutive cycles.
REQ-026 No receive enable exists; the block SHALL always listen and never drive ps2c or ps2d.

Reset
REQ-027 Reset SHALL force: FSM to IDLE, bit count 0, timeout counter 0, skip 0, ps2_data 0x00, ps2_new_data 0, frame_err 0, filtered clock 1, synchronizer flops and filter history to 1.
REQ-028 Reset asserted mid-frame SHALL drop the partial frame with no pulse; the first complete frame after release SHALL decode normally.

Structure
REQ-029 Shared package SHALL hold the frame-state encoding and the constants 0xF0 (BREAK) and 0xE0 (EXTENDED).
REQ-030 The synchronizer plus glitch filter SHALL be one sub-module, ps2_clk_filter, whose outputs are the filtered clock, a falling-edge strobe and the synced data.
REQ-031 Output format SHALL stay compatible with the existing keypad digit-entry consumer: a raw 8-bit make code plus a one-cycle strobe.

Verification (FILTER_LEN=8, TIMEOUT_CYC=2000, PS/2 bit period 400 clk)
REQ-032 Frame 0x69, parity 1, stop 1 -> one ps2_new_data pulse, ps2_data=0x69, frame_err stays 0.
REQ-033 Frames 0x70, 0xF0, 0x70 (parity 0 on each 0x70) -> exactly one pulse with ps2_data=0x70; ps2_data stays 0x70 afterwards.
REQ-034 Frame 0x16 with parity 1 (wrong) -> frame_err pulse one cycle after the stop-bit sample; no ps2_new_data; ps2_data unchanged.
REQ-035 Frame 0x72 with 3-cycle low glitches injected on ps2c mid-bit -> no extra bits sampled; ps2_data=0x72 with one pulse.
REQ-036 Start bit plus 5 data bits, then ps2c idle for 2500 clk -> frame_err pulse at count 2000; a following full 0x72 frame decodes correctly.
REQ-037 reset pulsed after 4 bits of a frame -> all outputs 0 with no pulse; the next 0x69 frame yields ps2_data=0x69 with one pulse.
